prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 18 +
 rtl/prog_loader_word_assembler.sv | 28 ++
 rtl/prog_loader.sv | 159 +++++++++++++++
 tb/tb_prog_loader.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader.
// Latency: n/a (types only).
// Backpressure: n/a.
package prog_loader_pkg;

  localparam int BYTE_W = 8;
  localparam int CSUM_W = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LO    = 3'd1,
    S_HI    = 3'd2,
    S_WRITE = 3'd3,
    S_CSUM  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/prog_loader_word_assembler.sv
// Builds one instruction word from a low byte followed by a high byte.
// Latency: a byte loaded on an edge is visible in word right after that edge.
// Backpressure: none; the caller only asserts lo_en/hi_en on accepted bytes.
// Ports: clk, rst_n, lo_en/hi_en (byte-lane load enables), data (byte in),
//        word (assembled WORD_W register, cleared by reset).
module word_assembler
  import prog_loader_pkg::*;
#(
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lo_en,
  input  logic              hi_en,
  input  logic [BYTE_W-1:0] data,
  output logic [WORD_W-1:0] word
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= '0;
    end else begin
      if (lo_en) word[BYTE_W-1:0]      <= data;
      if (hi_en) word[WORD_W-1:BYTE_W] <= data;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Streams bytes into program RAM as 16-bit words, then releases the CPU.
// Latency: RAM write strobe one cycle after the high byte; cpu_start one cycle after the last write.
// Backpressure: in_ready high only in LO/HI/CSUM; bytes are taken on in_valid && in_ready.
// Ports: clk, rst_n, go/base_addr/load_len (session start), in_valid/in_byte/in_ready
//        (byte stream), ram_w_en/ram_w_addr/ram_w_data (RAM write port),
//        cpu_start/start_pc (CPU release), busy, err (sticky, checksum build only).
// Optional feature macro: PROG_LOADER_CHECKSUM_EN adds a trailing checksum byte.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] load_len,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_byte,
  output logic              in_ready,
  output logic              ram_w_en,
  output logic [ADDR_W-1:0] ram_w_addr,
  output logic [WORD_W-1:0] ram_w_data,
  output logic              cpu_start,
  output logic [ADDR_W-1:0] start_pc,
  output logic              busy,
  output logic              err
);

  state_t            state;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] count;
  logic [ADDR_W-1:0] count_nxt;
  logic              take;
  logic              lo_en;
  logic              hi_en;

  assign take      = in_valid && in_ready;
  assign lo_en     = take && (state == S_LO);
  assign hi_en     = take && (state == S_HI);
  assign count_nxt = count + ADDR_W'(1);

  // The assembler register doubles as the RAM write data: it is stable
  // throughout the WRITE cycle because no byte is accepted there.
  word_assembler #(.WORD_W(WORD_W)) u_asm (
    .clk   (clk),
    .rst_n (rst_n),
    .lo_en (lo_en),
    .hi_en (hi_en),
    .data  (in_byte),
    .word  (ram_w_data)
  );

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [CSUM_W-1:0] sum;
  logic [CSUM_W-1:0] csum_total;

  assign csum_total = sum + in_byte;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
    end else if (state == S_IDLE && go) begin
      sum <= '0;
    end else if (lo_en || hi_en) begin
      sum <= csum_total;
    end
  end
`endif

  // Outputs are registered and updated together with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      in_ready   <= 1'b0;
      ram_w_en   <= 1'b0;
      ram_w_addr <= '0;
      cpu_start  <= 1'b0;
      err        <= 1'b0;
      start_pc   <= '0;
      len_q      <= '0;
      count      <= '0;
    end else begin
      ram_w_en  <= 1'b0;
      cpu_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (go) begin
            start_pc <= base_addr;
            len_q    <= load_len;
            count    <= '0;
            err      <= 1'b0;
            busy     <= 1'b1;
            if (load_len == '0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
              state    <= S_CSUM;
              in_ready <= 1'b1;
`else
              state     <= S_DONE;
              cpu_start <= 1'b1;
`endif
            end else begin
              state    <= S_LO;
              in_ready <= 1'b1;
            end
          end
        end
        S_LO: begin
          if (take) state <= S_HI;
        end
        S_HI: begin
          if (take) begin
            state      <= S_WRITE;
            in_ready   <= 1'b0;
            ram_w_en   <= 1'b1;
            ram_w_addr <= start_pc + count;  // wraps modulo 2^ADDR_W
          end
        end
        S_WRITE: begin
          count <= count_nxt;
          if (count_nxt < len_q) begin
            state    <= S_LO;
            in_ready <= 1'b1;
          end else begin
`ifdef PROG_LOADER_CHECKSUM_EN
            state    <= S_CSUM;
            in_ready <= 1'b1;
`else
            state     <= S_DONE;
            cpu_start <= 1'b1;
`endif
          end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (take) begin
            state     <= S_DONE;
            in_ready  <= 1'b0;
            err       <= (csum_total != '0);
            cpu_start <= (csum_total == '0);
          end
        end
`endif
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state    <= S_IDLE;
          busy     <= 1'b0;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        go;
  logic [7:0]  base_addr;
  logic [7:0]  load_len;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic        ram_w_en;
  logic [7:0]  ram_w_addr;
  logic [15:0] ram_w_data;
  logic        cpu_start;
  logic [7:0]  start_pc;
  logic        busy;
  logic        err;

  always #5 clk = ~clk;

  prog_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .go         (go),
    .base_addr  (base_addr),
    .load_len   (load_len),
    .in_valid   (in_valid),
    .in_byte    (in_byte),
    .in_ready   (in_ready),
    .ram_w_en   (ram_w_en),
    .ram_w_addr (ram_w_addr),
    .ram_w_data (ram_w_data),
    .cpu_start  (cpu_start),
    .start_pc   (start_pc),
    .busy       (busy),
    .err        (err)
  );

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t         exp_wr[$];
  logic [7:0]  exp_start[$];
  logic [15:0] words_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event not expected or not seen", name);
  endtask

  // Monitor: every write strobe / cpu_start must match the next expected one.
  wr_t        mon_e;
  logic [7:0] mon_s;
  always @(negedge clk) begin
    if (ram_w_en) begin
      if (exp_wr.size() == 0) flag_fail("unexpected_write");
      else begin
        mon_e = exp_wr.pop_front();
        check("wr_addr", 32'(ram_w_addr), 32'(mon_e.addr));
        check("wr_data", 32'(ram_w_data), 32'(mon_e.data));
      end
    end
    if (cpu_start) begin
      if (exp_start.size() == 0) flag_fail("unexpected_cpu_start");
      else begin
        mon_s = exp_start.pop_front();
        check("start_pc_at_start", 32'(start_pc), 32'(mon_s));
        check("err_at_start", 32'(err), 32'd0);
      end
    end
  end

  task automatic wait_idle();
    int g = 0;
    while (busy && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    check("session_end_busy", 32'(busy), 32'd0);
  endtask

  // Reference model: word i lands at (base+i) mod 256, low byte sent first.
  task automatic run_session(input logic [7:0] base, input logic [7:0] len,
                             input bit gaps, input bit poke, input bit bad);
    logic [7:0] bytes[$];
    logic [7:0] sum = 8'd0;
    bit         exp_err = 1'b0;
    for (int i = 0; i < int'(len); i++) begin
      exp_wr.push_back('{addr: 8'(int'(base) + i), data: words_q[i]});
      bytes.push_back(words_q[i][7:0]);
      bytes.push_back(words_q[i][15:8]);
      sum = 8'(sum + words_q[i][7:0] + words_q[i][15:8]);
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    begin
      logic [7:0] csum;
      csum = 8'(8'd0 - sum);
      if (bad) csum = 8'(csum - 8'd1);
      bytes.push_back(csum);
      exp_err = bad;
    end
`endif
    if (!exp_err) exp_start.push_back(base);
    base_addr = base;
    load_len  = len;
    go        = 1'b1;
    @(posedge clk); #1;
    go        = 1'b0;
    base_addr = 8'($urandom);
    for (int idx = 0; idx < bytes.size(); idx++) begin
      bit accepted = 1'b0;
      int guard    = 0;
      while (!accepted && guard < 100) begin
        go = poke && (idx == 1);
        if (go) begin
          base_addr = ~base;
          load_len  = 8'($urandom_range(1, 9));
        end
        in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        in_byte  = in_valid ? bytes[idx] : 8'($urandom);
        accepted = in_valid && in_ready;
        @(posedge clk); #1;
        guard++;
      end
      if (!accepted) flag_fail("byte_accept_timeout");
    end
    in_valid = 1'b0;
    go       = 1'b0;
    wait_idle();
    check("err_after_session", 32'(err), 32'(exp_err));
    check("start_pc_hold", 32'(start_pc), 32'(base));
  endtask

  task automatic rand_words(input int n);
    words_q.delete();
    for (int i = 0; i < n; i++) words_q.push_back(16'($urandom));
  endtask

  initial begin
    rst_n = 1'b0; go = 1'b0; base_addr = '0; load_len = '0;
    in_valid = 1'b0; in_byte = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_ram_w_en", 32'(ram_w_en), 0);
    check("rst_cpu_start", 32'(cpu_start), 0);
    check("rst_err", 32'(err), 0);
    check("rst_ram_w_addr", 32'(ram_w_addr), 0);
    check("rst_ram_w_data", 32'(ram_w_data), 0);
    check("rst_start_pc", 32'(start_pc), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic two-word load.
    words_q = '{16'h1234, 16'h5678};
    run_session(8'h10, 8'd2, 1'b0, 1'b0, 1'b0);

    // Address wrap from 0xFF to 0x00, with stalls and a go while busy.
    rand_words(2);
    run_session(8'hFF, 8'd2, 1'b1, 1'b1, 1'b0);

    // Zero-length session.
    words_q.delete();
`ifdef PROG_LOADER_CHECKSUM_EN
    run_session(8'h33, 8'd0, 1'b0, 1'b0, 1'b0);
`else
    begin
      bit seen;
      exp_start.push_back(8'h33);
      base_addr = 8'h33; load_len = 8'd0; go = 1'b1;
      @(posedge clk); #1;
      go   = 1'b0;
      seen = cpu_start;
      if (!seen) begin
        @(posedge clk); #1;
        seen = cpu_start;
      end
      check("len0_cpu_start_latency", 32'(seen), 32'd1);
      wait_idle();
    end
`endif

    // Reset mid-word: everything clears at once, partial word is dropped.
    base_addr = 8'h40; load_len = 8'd2; go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0; in_valid = 1'b1; in_byte = 8'hA5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_in_ready", 32'(in_ready), 0);
    check("mid_rst_ram_w_en", 32'(ram_w_en), 0);
    check("mid_rst_ram_w_data", 32'(ram_w_data), 0);
    check("mid_rst_start_pc", 32'(start_pc), 0);
    check("mid_rst_ram_w_addr", 32'(ram_w_addr), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rand_words(3);
    run_session(8'h40, 8'd3, 1'b0, 1'b0, 1'b0);

    // Randomized sessions.
    for (int s = 0; s < 12; s++) begin
      int n;
      n = $urandom_range(1, 6);
      rand_words(n);
      run_session(8'($urandom), 8'(n), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    words_q = '{16'h0201};
    run_session(8'h20, 8'd1, 1'b0, 1'b0, 1'b0);
    words_q = '{16'h0201};
    run_session(8'h20, 8'd1, 1'b0, 1'b0, 1'b1);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("leftover_writes", 32'(exp_wr.size()), 0);
    check("leftover_cpu_starts", 32'(exp_start.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
